// File: rtl/cpu_debug_ctl.sv
// Host debug controller: halt/run/single-step the pipeline, PC breakpoint, state readback.
// Latency: response one cycle after command accept; STEP n>0 answers when the core re-halts.
// Backpressure: one command in flight; cmd_ready low while stepping or a response is unread.
// Ports: clk/rst_b (async active-low); pc_4a, kill_4a, stall_2a, st__top_0_2a observed pipeline
//   state; cmd_valid/cmd_ready/cmd_op/cmd_data host command channel; rsp_valid/rsp_ready/rsp_data
//   response channel; dbg_halt registered freeze, ORed into the stage-2 stall outside this block.
module cpu_debug_ctl #(
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] pc_4a,
  input  logic        kill_4a,
  input  logic        stall_2a,
  input  logic [34:0] st__top_0_2a,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        dbg_halt
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_e;

  localparam logic [2:0] OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3,
                         OP_SETBP = 3'd4, OP_CLRBP = 3'd5, OP_READ = 3'd6;

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic        bp_en_q, bp_en_d;
  logic        bp_hit_q, bp_hit_d;
  logic [31:0] bp_addr_q, bp_addr_d;
  logic [15:0] step_cnt_q, step_cnt_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        accept, bp_match, load_stat, load_read;
  logic [31:0] stat_cur, stat_nxt, read_val;

  // A micro-stall does not pause stepping or the cycle counter, so stall_2a has no effect here.
  logic unused_stall;
  assign unused_stall = stall_2a;

  assign cmd_ready = (state_q != S_STEP) & ~rsp_valid_q;
  assign accept    = cmd_valid & cmd_ready;
  assign bp_match  = bp_en_q & ~kill_4a & ~halt_q & (state_q != S_HALT) & (pc_4a == bp_addr_q);
  assign stat_cur  = {28'b0, bp_hit_q, bp_en_q, state_q == S_STEP, halt_q};

  always_comb begin
    case (cmd_data[2:0])
      3'd0:    read_val = pc_4a;
      3'd1:    read_val = st__top_0_2a[31:0];
      3'd2:    read_val = {29'b0, st__top_0_2a[34:32]};
      3'd3:    read_val = cyc_cnt_q;
      3'd4:    read_val = stat_cur;
      3'd5:    read_val = bp_addr_q;
      default: read_val = 32'hDEAD_BEEF;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bp_en_d     = bp_en_q;
    bp_hit_d    = bp_hit_q;
    bp_addr_d   = bp_addr_q;
    step_cnt_d  = step_cnt_q;
    cyc_cnt_d   = halt_q ? cyc_cnt_q : cyc_cnt_q + 32'd1;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    load_stat   = 1'b0;
    load_read   = 1'b0;

    // Step countdown: the cycle holding count 1 is the last free-running one.
    if (state_q == S_STEP) begin
      step_cnt_d = step_cnt_q - 16'd1;
      if (step_cnt_q == 16'd1) begin
        state_d   = S_HALT;
        load_stat = 1'b1;
      end
    end

    if (accept) begin
      case (cmd_op)
        OP_HALT: begin
          state_d   = S_HALT;
          load_stat = 1'b1;
        end
        OP_RUN: begin
          state_d   = S_RUN;
          bp_hit_d  = 1'b0;
          load_stat = 1'b1;
        end
        OP_STEP: begin
          // Zero-length step, or a step while running, just reports status.
          if (cmd_data[15:0] != 16'd0 && state_q == S_HALT) begin
            state_d    = S_STEP;
            step_cnt_d = cmd_data[15:0];
          end else begin
            load_stat = 1'b1;
          end
        end
        OP_SETBP: begin
          bp_addr_d = cmd_data;
          bp_en_d   = 1'b1;
          bp_hit_d  = 1'b0;
          load_stat = 1'b1;
        end
        OP_CLRBP: begin
          bp_en_d   = 1'b0;
          bp_hit_d  = 1'b0;
          load_stat = 1'b1;
        end
        OP_READ: load_read = 1'b1;
        default: load_stat = 1'b1;
      endcase
    end

    // Breakpoint overrides any same-cycle command's state change; a hit while stepping
    // terminates the step and releases its pending response.
    if (bp_match) begin
      state_d    = S_HALT;
      bp_hit_d   = 1'b1;
      step_cnt_d = 16'd0;
      if (state_q == S_STEP) load_stat = 1'b1;
    end

    halt_d   = (state_d == S_HALT);
    stat_nxt = {28'b0, bp_hit_d, bp_en_d, state_d == S_STEP, halt_d};

    if (load_read) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = read_val;
    end else if (load_stat) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = stat_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= HALT_ON_RESET ? S_HALT : S_RUN;
      halt_q      <= HALT_ON_RESET;
      bp_en_q     <= 1'b0;
      bp_hit_q    <= 1'b0;
      bp_addr_q   <= 32'h0;
      step_cnt_q  <= 16'h0;
      cyc_cnt_q   <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      bp_en_q     <= bp_en_d;
      bp_hit_q    <= bp_hit_d;
      bp_addr_q   <= bp_addr_d;
      step_cnt_q  <= step_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign dbg_halt  = halt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cpu_debug_ctl.sv
// Testbench for cpu_debug_ctl: directed scenarios plus randomized command traffic,
// checked against a command-level model of the debug controller kept in this file.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cpu_debug_ctl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] pc_4a = 32'h0;
  logic        kill_4a = 1'b0;
  logic        stall_2a = 1'b0;
  logic [34:0] st_top = 35'h0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        dbg_halt;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  logic        m_halt, m_bp_en, m_bp_hit;
  logic [31:0] m_bp_addr, m_cyc;
  int          m_step_left;

  cpu_debug_ctl #(.HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .rst_b(rst_b), .pc_4a(pc_4a), .kill_4a(kill_4a), .stall_2a(stall_2a),
    .st__top_0_2a(st_top), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dbg_halt(dbg_halt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_stat();
    return {28'b0, m_bp_hit, m_bp_en, m_step_left != 0, m_halt};
  endfunction

  // One clock: the core's cycle count advances for every cycle it was not halted;
  // a running step re-halts once its budget is used up.
  task automatic tick();
    @(posedge clk);
    if (!m_halt) m_cyc = m_cyc + 32'd1;
    if (m_step_left > 0) begin
      m_step_left--;
      if (m_step_left == 0) m_halt = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; pc_4a = 32'h0; kill_4a = 1'b0;
    stall_2a = 1'b0; st_top = 35'h0;
    #22;
    @(posedge clk); #1;
    rst_b = 1'b1;
    m_halt = 1'b0; m_bp_en = 1'b0; m_bp_hit = 1'b0; m_bp_addr = 32'h0; m_cyc = 32'h0;
    m_step_left = 0;
  endtask

  // Present a command until accepted, update the model, and return the expected response.
  task automatic send_cmd(input logic [2:0] op, input logic [31:0] data,
                          output logic [31:0] exp, output bit ok);
    int w;
    logic [31:0] rd;
    w = 0;
    exp = 32'h0;
    while (!cmd_ready && w < 200) begin tick(); w++; end
    ok = cmd_ready;
    if (!ok) return;
    case (data[2:0])
      3'd0:    rd = pc_4a;
      3'd1:    rd = st_top[31:0];
      3'd2:    rd = {29'b0, st_top[34:32]};
      3'd3:    rd = m_cyc;
      3'd4:    rd = m_stat();
      3'd5:    rd = m_bp_addr;
      default: rd = 32'hDEAD_BEEF;
    endcase
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
    case (op)
      3'd1: m_halt = 1'b1;
      3'd2: begin m_halt = 1'b0; m_bp_hit = 1'b0; end
      3'd3: if (data[15:0] != 16'd0 && m_halt) begin
              m_halt = 1'b0; m_step_left = int'(data[15:0]);
            end
      3'd4: begin m_bp_addr = data; m_bp_en = 1'b1; m_bp_hit = 1'b0; end
      3'd5: begin m_bp_en = 1'b0; m_bp_hit = 1'b0; end
      default: ;
    endcase
    if (op == 3'd6) exp = rd;
    else if (m_step_left != 0) exp = {28'b0, m_bp_hit, m_bp_en, 2'b01};
    else exp = m_stat();
  endtask

  task automatic get_rsp(input int delay, output logic [31:0] got, output bit ok);
    int w;
    w = 0;
    got = 32'h0;
    while (!rsp_valid && w < 300) begin tick(); w++; end
    ok = rsp_valid;
    if (!ok) return;
    got = rsp_data;
    repeat (delay) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic [2:0] op, input logic [31:0] data, input int delay,
                      output logic [31:0] exp, output logic [31:0] got, output bit ok);
    bit ok1, ok2;
    send_cmd(op, data, exp, ok1);
    got = 32'h0;
    ok2 = 1'b0;
    if (ok1) get_rsp(delay, got, ok2);
    ok = ok1 & ok2;
  endtask

  task automatic test_reset();
    logic [31:0] exp, got;
    bit ok;
    do_reset();
    total_cnt++;
    if ({dbg_halt, cmd_ready, rsp_valid, rsp_data} !== {1'b0, 1'b1, 1'b0, 32'h0})
      $display("FAIL reset_outputs: halt/rdy/vld/data=%b%b%b %h want 010 0", dbg_halt,
               cmd_ready, rsp_valid, rsp_data);
    else pass_cnt++;
    xact(3'd6, 32'd4, 0, exp, got, ok);
    total_cnt++;
    if (!ok || got !== 32'h0) $display("FAIL reset_read_stat: got %h ok=%0d want 0", got, ok);
    else pass_cnt++;
  endtask

  task automatic test_step();
    logic [31:0] exp, got;
    bit ok;
    do_reset();
    repeat (9) tick();
    send_cmd(3'd1, 32'h0, exp, ok);
    total_cnt++;
    if (!ok || dbg_halt !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 32'h1)
      $display("FAIL halt_cmd: halt=%b vld=%b data=%h want 1 1 1", dbg_halt, rsp_valid, rsp_data);
    else pass_cnt++;
    get_rsp(0, got, ok);
    send_cmd(3'd3, 32'd3, exp, ok);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (!ok || dbg_halt !== 1'b0) $display("FAIL step3_low[%0d]: halt=%b want 0", i, dbg_halt);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (dbg_halt !== 1'b1 || rsp_valid !== 1'b1)
      $display("FAIL step3_rehalt: halt=%b vld=%b want 1 1", dbg_halt, rsp_valid);
    else pass_cnt++;
    get_rsp(0, got, ok);
    total_cnt++;
    if (!ok || got !== 32'h1) $display("FAIL step3_rsp: got %h want 1", got);
    else pass_cnt++;
    xact(3'd6, 32'd3, 0, exp, got, ok);
    total_cnt++;
    if (!ok || got !== 32'd13 || got !== exp)
      $display("FAIL step3_cyc_cnt: got %0d want 13 (model %0d)", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_bp();
    logic [31:0] exp, got;
    bit ok;
    do_reset();
    xact(3'd4, 32'h100, 0, exp, got, ok);
    total_cnt++;
    if (!ok || got !== 32'h4) $display("FAIL set_bp_rsp: got %h want 4", got);
    else pass_cnt++;
    pc_4a = 32'h100; kill_4a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (dbg_halt !== 1'b0) $display("FAIL bp_killed[%0d]: halt=%b want 0", i, dbg_halt);
      else pass_cnt++;
    end
    kill_4a = 1'b0;
    tick();
    m_halt = 1'b1; m_bp_hit = 1'b1;
    total_cnt++;
    if (dbg_halt !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL bp_hit_halt: halt=%b vld=%b want 1 0", dbg_halt, rsp_valid);
    else pass_cnt++;
    pc_4a = 32'h0;
    xact(3'd6, 32'd4, 0, exp, got, ok);
    total_cnt++;
    if (!ok || got !== 32'hD) $display("FAIL bp_read_stat: got %h want d", got);
    else pass_cnt++;
    xact(3'd2, 32'h0, 0, exp, got, ok);
    total_cnt++;
    if (!ok || got !== 32'h4 || dbg_halt !== 1'b0)
      $display("FAIL bp_run_rsp: got %h halt=%b want 4 0", got, dbg_halt);
    else pass_cnt++;
  endtask

  task automatic test_step_bp();
    logic [31:0] exp, got;
    bit ok;
    do_reset();
    xact(3'd1, 32'h0, 0, exp, got, ok);
    xact(3'd4, 32'h200, 0, exp, got, ok);
    total_cnt++;
    if (!ok || got !== 32'h5) $display("FAIL set_bp_halted: got %h want 5", got);
    else pass_cnt++;
    send_cmd(3'd3, 32'd100, exp, ok);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (!ok || dbg_halt !== 1'b0) $display("FAIL step_bp_low[%0d]: halt=%b want 0", i, dbg_halt);
      else pass_cnt++;
      tick();
    end
    pc_4a = 32'h200;
    tick();
    m_step_left = 0; m_halt = 1'b1; m_bp_hit = 1'b1;
    pc_4a = 32'h0;
    total_cnt++;
    if (dbg_halt !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 32'hD)
      $display("FAIL step_bp_end: halt=%b vld=%b data=%h want 1 1 d", dbg_halt, rsp_valid, rsp_data);
    else pass_cnt++;
    get_rsp(0, got, ok);
    xact(3'd6, 32'd3, 0, exp, got, ok);
    total_cnt++;
    if (!ok || got !== exp) $display("FAIL step_bp_cyc: got %0d want %0d", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp, got;
    bit ok, stable;
    do_reset();
    xact(3'd4, 32'h1234_5670, 0, exp, got, ok);
    send_cmd(3'd6, 32'd5, exp, ok);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 32'h0;
    stable = ok;
    for (int i = 0; i < 20; i++) begin
      if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, exp, 1'b0}) stable = 1'b0;
      tick();
    end
    total_cnt++;
    if (!stable || exp !== 32'h1234_5670)
      $display("FAIL bp_hold: vld=%b data=%h rdy=%b want 1 %h 0", rsp_valid, rsp_data, cmd_ready, exp);
    else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || dbg_halt !== 1'b0)
      $display("FAIL bp_release: vld=%b rdy=%b halt=%b want 0 1 0", rsp_valid, cmd_ready, dbg_halt);
    else pass_cnt++;
    tick();
    cmd_valid = 1'b0;
    m_halt = 1'b1;
    total_cnt++;
    if (dbg_halt !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== m_stat())
      $display("FAIL bp_next_cmd: halt=%b vld=%b data=%h want 1 1 %h", dbg_halt, rsp_valid,
               rsp_data, m_stat());
    else pass_cnt++;
    get_rsp(0, got, ok);
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp, got;
    bit ok;
    do_reset();
    xact(3'd1, 32'h0, 0, exp, got, ok);
    send_cmd(3'd3, 32'd50, exp, ok);
    repeat (5) tick();
    rst_b = 1'b0;
    #1;
    total_cnt++;
    if ({dbg_halt, cmd_ready, rsp_valid, rsp_data} !== {1'b0, 1'b1, 1'b0, 32'h0})
      $display("FAIL reset_mid_step: halt/rdy/vld/data=%b%b%b %h want 010 0", dbg_halt,
               cmd_ready, rsp_valid, rsp_data);
    else pass_cnt++;
    do_reset();
    send_cmd(3'd6, 32'd6, exp, ok);
    tick();
    rst_b = 1'b0;
    #1;
    total_cnt++;
    if (!ok || {rsp_valid, rsp_data} !== {1'b0, 32'h0})
      $display("FAIL reset_mid_rsp: vld=%b data=%h want 0 0", rsp_valid, rsp_data);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] exp, got, data;
    logic [2:0]  op;
    bit ok;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      case (op)
        3'd3:    data = $urandom_range(0, 6);
        3'd4:    data = $urandom & 32'hFFFF_FFFE;
        3'd6:    data = $urandom_range(0, 7);
        default: data = $urandom;
      endcase
      // PC kept odd and breakpoints even so traffic never trips a breakpoint.
      pc_4a = $urandom | 32'h1;
      st_top = {3'($urandom_range(0, 7)), 32'($urandom)};
      xact(op, data, $urandom_range(0, 3), exp, got, ok);
      total_cnt++;
      if (!ok || got !== exp || dbg_halt !== m_halt)
        $display("FAIL rand[%0d] op=%0d: got %h halt=%b want %h halt=%b", i, op, got, dbg_halt,
                 exp, m_halt);
      else pass_cnt++;
    end
    xact(3'd6, 32'd3, 0, exp, got, ok);
    total_cnt++;
    if (!ok || got !== exp) $display("FAIL rand_cyc_cnt: got %0d want %0d", got, exp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_step();
    test_bp();
    test_step_bp();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
